line_fill_mem: RTL and testbench

Memory-side responder for the direct-mapped cache's line interface. It accepts one whole-block read or write request at a time, models main-memory latency, and moves the block one word per cycle through a word-wide RAM. It returns a full line, or a write acknowledge, with a valid/ready handshake. It sits between the cache's `mem_address`/`mem_data_in` side and backing storage.

---
 rtl/cache_pkg.sv | 18 +
 rtl/word_ram.sv | 30 +++
 rtl/line_fill_mem.sv | 151 +++++++++++++++
 tb/tb_line_fill_mem.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared definitions for the cache line interface and its memory-side
// responder.
//   lfm_state_t : FSM states of line_fill_mem
//   line_width  : bits in one cache line (word width times words per line)
package cache_pkg;

    typedef enum logic [1:0] {
        LFM_IDLE = 2'd0,
        LFM_WAIT = 2'd1,
        LFM_BEAT = 2'd2,
        LFM_RESP = 2'd3
    } lfm_state_t;

    function automatic int line_width(input int data_width, input int block_size);
        return data_width * (2 ** block_size);
    endfunction

endpackage

// File: rtl/word_ram.sv
// Word-wide backing RAM for line_fill_mem.
// Synchronous write, combinational read, single port. Contents are not
// cleared by reset.
//   clk   : clock
//   we    : write enable
//   addr  : word address
//   wdata : write data
//   rdata : read data at addr (combinational)
module word_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

    assign rdata = mem_q[addr];

endmodule

// File: rtl/line_fill_mem.sv
// Memory-side responder for the cache line interface. Accepts one whole-line
// read or write, waits LATENCY cycles, then moves the line one word per cycle
// through word_ram and returns the line (or the echoed write line).
//   clk, rst_n            : clock, async active-low reset
//   req_valid/req_ready   : request handshake (ready only in IDLE)
//   req_write             : 1 = write line, 0 = read line
//   req_address           : word address, low BLOCK_SIZE bits ignored
//   req_data              : line to write
//   resp_valid/resp_ready : response handshake
//   resp_data             : line read, or echo of the written line
//
// state | meaning
// IDLE  | ready for a request
// WAIT  | modelling memory latency, lat_q counts down to 0
// BEAT  | one word per cycle, beat_q = word index
// RESP  | response held until resp_ready
module line_fill_mem
    import cache_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 30,
    parameter int BLOCK_SIZE    = 3,
    parameter int MEM_DEPTH     = 12,
    parameter int LATENCY       = 4
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic                                          req_valid,
    output logic                                          req_ready,
    input  logic                                          req_write,
    input  logic [ADDRESS_WIDTH-1:0]                      req_address,
    input  logic [line_width(DATA_WIDTH, BLOCK_SIZE)-1:0] req_data,
    output logic                                          resp_valid,
    input  logic                                          resp_ready,
    output logic [line_width(DATA_WIDTH, BLOCK_SIZE)-1:0] resp_data
);

    localparam int LINE_W = line_width(DATA_WIDTH, BLOCK_SIZE);
    localparam int BASE_W = MEM_DEPTH - BLOCK_SIZE;
    localparam int LAT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'((LATENCY > 0) ? LATENCY - 1 : 0);

    lfm_state_t              state_q, state_d;
    logic [LAT_W-1:0]        lat_q, lat_d;
    logic [BLOCK_SIZE-1:0]   beat_q, beat_d;
    logic [BASE_W-1:0]       base_q, base_d;
    logic                    write_q, write_d;
    logic [LINE_W-1:0]       line_q, line_d;
    logic [LINE_W-1:0]       resp_data_q, resp_data_d;

    logic                    ram_we;
    logic [MEM_DEPTH-1:0]    ram_addr;
    logic [DATA_WIDTH-1:0]   ram_wdata;
    logic [DATA_WIDTH-1:0]   ram_rdata;

    // Address bits above the RAM depth wrap away; low bits are line offset.
    logic                    unused_addr;
    assign unused_addr = ^{req_address[ADDRESS_WIDTH-1:MEM_DEPTH],
                           req_address[BLOCK_SIZE-1:0]};

    assign ram_addr  = {base_q, beat_q};
    assign ram_wdata = line_q[int'(beat_q)*DATA_WIDTH +: DATA_WIDTH];
    // Reset forces state_q to IDLE asynchronously, so no beat write can
    // land on an edge while reset is held.
    assign ram_we    = (state_q == LFM_BEAT) && write_q;

    word_ram #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(MEM_DEPTH)
    ) u_word_ram (
        .clk  (clk),
        .we   (ram_we),
        .addr (ram_addr),
        .wdata(ram_wdata),
        .rdata(ram_rdata)
    );

    always_comb begin
        state_d     = state_q;
        lat_d       = lat_q;
        beat_d      = beat_q;
        base_d      = base_q;
        write_d     = write_q;
        line_d      = line_q;
        resp_data_d = resp_data_q;
        case (state_q)
            LFM_IDLE: begin
                if (req_valid) begin
                    base_d  = req_address[MEM_DEPTH-1:BLOCK_SIZE];
                    write_d = req_write;
                    line_d  = req_data;
                    beat_d  = '0;
                    if (LATENCY == 0) begin
                        state_d = LFM_BEAT;
                    end else begin
                        state_d = LFM_WAIT;
                        lat_d   = LAT_LOAD;
                    end
                end
            end
            LFM_WAIT: begin
                if (lat_q == '0) begin
                    state_d = LFM_BEAT;
                    beat_d  = '0;
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end
            LFM_BEAT: begin
                resp_data_d[int'(beat_q)*DATA_WIDTH +: DATA_WIDTH] =
                    write_q ? ram_wdata : ram_rdata;
                if (beat_q == '1) begin
                    state_d = LFM_RESP;
                end else begin
                    beat_d = beat_q + BLOCK_SIZE'(1);
                end
            end
            LFM_RESP: begin
                if (resp_ready) begin
                    state_d = LFM_IDLE;
                end
            end
            default: state_d = LFM_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= LFM_IDLE;
            lat_q       <= '0;
            beat_q      <= '0;
            base_q      <= '0;
            write_q     <= 1'b0;
            line_q      <= '0;
            resp_data_q <= '0;
        end else begin
            state_q     <= state_d;
            lat_q       <= lat_d;
            beat_q      <= beat_d;
            base_q      <= base_d;
            write_q     <= write_d;
            line_q      <= line_d;
            resp_data_q <= resp_data_d;
        end
    end

    assign req_ready  = (state_q == LFM_IDLE);
    assign resp_valid = (state_q == LFM_RESP);
    assign resp_data  = resp_data_q;

endmodule

// File: tb/tb_line_fill_mem.sv
// Directed bench for line_fill_mem: one instance with default parameters
// and one built with LATENCY=0, sharing request payload and resp_ready.
module tb_line_fill_mem;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req_write;
    logic [29:0]  req_address;
    logic [255:0] req_data;
    logic         resp_ready;

    logic         req_valid, req_ready, resp_valid;
    logic [255:0] resp_data;
    logic         req_valid0, req_ready0, resp_valid0;
    logic [255:0] resp_data0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    line_fill_mem dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_address(req_address),
        .req_data   (req_data),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data)
    );

    line_fill_mem #(.LATENCY(0)) dut0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid0),
        .req_ready  (req_ready0),
        .req_write  (req_write),
        .req_address(req_address),
        .req_data   (req_data),
        .resp_valid (resp_valid0),
        .resp_ready (resp_ready),
        .resp_data  (resp_data0)
    );

    function automatic logic [255:0] mk_line(input logic [31:0] base, input bit inc);
        logic [255:0] l;
        for (int k = 0; k < 8; k++) l[k*32 +: 32] = inc ? base + 32'(k) : base;
        return l;
    endfunction

    // Drives one transaction (sel=1 targets the LATENCY=0 instance) with
    // resp_ready high; lat = edges from accept to resp_valid, -1 on timeout.
    task automatic txn(input bit sel, input logic wr, input logic [29:0] addr,
                       input logic [255:0] data, output logic [255:0] line,
                       output int lat, output logic rdy_after);
        req_write   = wr;
        req_address = addr;
        req_data    = data;
        resp_ready  = 1'b1;
        if (sel) req_valid0 = 1'b1; else req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid  = 1'b0;
        req_valid0 = 1'b0;
        rdy_after  = sel ? req_ready0 : req_ready;
        lat = 0;
        while (!(sel ? resp_valid0 : resp_valid) && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        line = sel ? resp_data0 : resp_data;
        if (lat >= 40) lat = -1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; req_valid = 0; req_valid0 = 0; req_write = 0;
        req_address = '0; req_data = '0; resp_ready = 0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
        n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_resp_valid got %b want 0", resp_valid); end
        n_cmp++; if (resp_data !== '0) begin n_bad++; $display("FAIL reset_resp_data got %h want 0", resp_data); end
        n_cmp++; if (req_ready0 !== 1'b1) begin n_bad++; $display("FAIL reset_req_ready0 got %b want 1", req_ready0); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_write;
        logic [255:0] l, exp; int lat; logic r;
        exp = mk_line(32'h1000_0000, 1);
        txn(0, 1'b1, 30'h40, exp, l, lat, r);
        n_cmp++; if (r !== 1'b0) begin n_bad++; $display("FAIL write_ready_drop got %b want 0", r); end
        n_cmp++; if (lat != 12) begin n_bad++; $display("FAIL write_latency got %0d want 12", lat); end
        n_cmp++; if (l !== exp) begin n_bad++; $display("FAIL write_echo got %h want %h", l, exp); end
    endtask

    task automatic test_read;
        logic [255:0] l, exp; int lat; logic r;
        exp = mk_line(32'h1000_0000, 1);
        txn(0, 1'b0, 30'h45, '0, l, lat, r);
        n_cmp++; if (lat != 12) begin n_bad++; $display("FAIL read_latency got %0d want 12", lat); end
        n_cmp++; if (l !== exp) begin n_bad++; $display("FAIL read_data got %h want %h", l, exp); end
    endtask

    task automatic test_hold;
        logic [255:0] exp1, exp2; int lat;
        exp1 = mk_line(32'h1000_0000, 1);
        exp2 = mk_line(32'h2000_0000, 1);
        req_write = 0; req_address = 30'h40; req_valid = 1; resp_ready = 0;
        @(posedge clk); #1;
        req_valid = 0;
        lat = 0;
        while (!resp_valid && lat < 40) begin @(posedge clk); #1; lat++; end
        n_cmp++; if (lat != 12) begin n_bad++; $display("FAIL hold_latency got %0d want 12", lat); end
        req_valid = 1; req_write = 1; req_address = 30'h200; req_data = exp2;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_cmp++; if (resp_valid !== 1'b1) begin n_bad++; $display("FAIL hold_valid[%0d] got %b want 1", i, resp_valid); end
            n_cmp++; if (resp_data !== exp1) begin n_bad++; $display("FAIL hold_data[%0d] got %h want %h", i, resp_data, exp1); end
            n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL hold_req_ready[%0d] got %b want 0", i, req_ready); end
        end
        resp_ready = 1;
        @(posedge clk); #1;
        n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL hold_release_valid got %b want 0", resp_valid); end
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL hold_idle_ready got %b want 1", req_ready); end
        @(posedge clk); #1;
        req_valid = 0;
        n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL hold_second_accept got %b want 0", req_ready); end
        lat = 0;
        while (!resp_valid && lat < 40) begin @(posedge clk); #1; lat++; end
        n_cmp++; if (lat != 12) begin n_bad++; $display("FAIL hold_second_latency got %0d want 12", lat); end
        n_cmp++; if (resp_data !== exp2) begin n_bad++; $display("FAIL hold_second_echo got %h want %h", resp_data, exp2); end
        @(posedge clk); #1;
        resp_ready = 0;
    endtask

    task automatic test_wrap;
        logic [255:0] l, exp; int lat; logic r;
        exp = mk_line(32'h3000_0000, 1);
        txn(0, 1'b1, 30'h1000, exp, l, lat, r);
        txn(0, 1'b0, 30'h0000, '0, l, lat, r);
        n_cmp++; if (l !== exp) begin n_bad++; $display("FAIL wrap_data got %h want %h", l, exp); end
    endtask

    task automatic test_latency0;
        logic [255:0] l, exp; int lat; logic r;
        exp = mk_line(32'h4000_0000, 1);
        txn(1, 1'b0, 30'hFF8, '0, l, lat, r);
        n_cmp++; if (lat != 8) begin n_bad++; $display("FAIL lat0_read_latency got %0d want 8", lat); end
        txn(1, 1'b1, 30'hFF8, exp, l, lat, r);
        n_cmp++; if (lat != 8) begin n_bad++; $display("FAIL lat0_write_latency got %0d want 8", lat); end
        n_cmp++; if (l !== exp) begin n_bad++; $display("FAIL lat0_echo got %h want %h", l, exp); end
        txn(1, 1'b0, 30'hFF8, '0, l, lat, r);
        n_cmp++; if (lat != 8) begin n_bad++; $display("FAIL lat0_reread_latency got %0d want 8", lat); end
        n_cmp++; if (l !== exp) begin n_bad++; $display("FAIL lat0_reread_data got %h want %h", l, exp); end
    endtask

    task automatic test_reset_mid;
        logic [255:0] l, exp; int lat; logic r;
        int words_done;
        txn(0, 1'b1, 30'h80, '0, l, lat, r);
        req_write = 1; req_address = 30'h80; req_data = mk_line(32'hAAAA_AAAA, 0);
        req_valid = 1;
        @(posedge clk); #1;
        req_valid = 0;
        // Accept edge E0; WAIT ends at E4; word k is written at edge E5+k.
        // Stopping after E7 leaves words 0..2 committed, beat 3 in flight.
        repeat (7) @(posedge clk);
        #1;
        words_done = 7 - 4;
        rst_n = 0;
        #1;
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL midrst_req_ready got %b want 1", req_ready); end
        n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_resp_valid got %b want 0", resp_valid); end
        n_cmp++; if (resp_data !== '0) begin n_bad++; $display("FAIL midrst_resp_data got %h want 0", resp_data); end
        @(posedge clk);
        @(negedge clk); rst_n = 1;
        @(posedge clk); #1;
        exp = '0;
        for (int k = 0; k < words_done; k++) exp[k*32 +: 32] = 32'hAAAA_AAAA;
        txn(0, 1'b0, 30'h80, '0, l, lat, r);
        n_cmp++; if (l !== exp) begin n_bad++; $display("FAIL midrst_readback got %h want %h", l, exp); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_hold();
        test_wrap();
        test_latency0();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
